// File: rtl/fmul_checker.sv
`default_nettype none
// ============================================================================
//  Module   : fmul_checker
//  Purpose  : Pairs fmul results with delayed operands, checks IEEE-754
//             single-precision invariants, keeps pass/error statistics and
//             captures the first failing {op1, op2, result} triple.
//  Option   : FMUL_CHK_MANT_EN adds a registered mantissa check (latency 2).
//  Revision : 1.0 - initial release
// ============================================================================
module fmul_checker #(
    parameter int LATENCY     = 1,
    parameter int HALT_ON_ERR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] result,
    output logic [31:0] pass_count,
    output logic [15:0] err_count,
    output logic        err_flag,
    output logic [95:0] first_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] c_fill_last = 3'(LATENCY - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_fill, w_fill_nxt;
    logic [63:0] r_dl [LATENCY];
    logic [63:0] w_dl_in [LATENCY];

    logic [31:0] r_pass_count;
    logic [15:0] r_err_count;
    logic        r_err_flag;
    logic [95:0] r_first_err;

    // ------------------------------------------------------------------
    // Operand delay line: advances only on enabled cycles
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dl
        if (gi == 0) begin : g_head
            assign w_dl_in[gi] = {op1, op2};
        end else begin : g_tail
            assign w_dl_in[gi] = r_dl[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) r_dl[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < LATENCY; i++) r_dl[i] <= w_dl_in[i];
        end
    end

    // ------------------------------------------------------------------
    // Exponent / sign / special-case rules on the aligned triple
    // ------------------------------------------------------------------
    logic [31:0]       w_a, w_b;
    logic [7:0]        w_ea, w_eb, w_er;
    logic [22:0]       w_rf;
    logic signed [9:0] w_e;
    logic              w_exp_ok, w_rule5, w_r_nan, w_sign_ok, w_base_ok, w_chk;

    assign {w_a, w_b} = r_dl[LATENCY-1];
    assign w_ea = w_a[30:23];
    assign w_eb = w_b[30:23];
    assign w_er = result[30:23];
    assign w_rf = result[22:0];
    assign w_e  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

    always_comb begin
        w_exp_ok = 1'b0;
        w_rule5  = 1'b0;
        if (w_ea == 8'hFF || w_eb == 8'hFF) begin
            w_exp_ok = (w_er == 8'hFF);
        end else if (w_ea == 8'h00 || w_eb == 8'h00) begin
            w_exp_ok = (w_er == 8'h00) && (w_rf == 23'd0);
        end else if (w_e >= 10'sd254) begin
            w_exp_ok = (w_er >= 8'd254);
        end else if (w_e <= 10'sd0) begin
            w_exp_ok = (w_er <= 8'd1);
        end else begin
            w_rule5  = 1'b1;
            w_exp_ok = ($signed({2'b00, w_er}) == w_e) ||
                       ($signed({2'b00, w_er}) == w_e + 10'sd1);
        end
    end

    // A NaN result carries no meaningful sign
    assign w_r_nan   = (w_er == 8'hFF) && (w_rf != 23'd0);
    assign w_sign_ok = w_r_nan || (result[31] == (w_a[31] ^ w_b[31]));
    assign w_base_ok = w_exp_ok && w_sign_ok;
    assign w_chk     = (r_state == S_CHECK);

    logic        w_upd_valid, w_upd_fail;
    logic [95:0] w_upd_triple;

`ifdef FMUL_CHK_MANT_EN
    logic [47:0]       w_prod;
    logic              r_s1_valid, r_s1_base_ok, r_s1_rule5;
    logic signed [9:0] r_s1_e;
    logic [24:0]       r_s1_prod;
    logic [95:0]       r_s1_triple;
    logic signed [9:0] w_expn;
    logic [22:0]       w_frac;
    logic [30:0]       w_expect, w_got;
    logic              w_mant_ok;
    logic              w_unused_mant;

    assign w_prod = {24'd0, 1'b1, w_a[22:0]} * {24'd0, 1'b1, w_b[22:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_base_ok <= 1'b0;
            r_s1_rule5   <= 1'b0;
            r_s1_e       <= '0;
            r_s1_prod    <= '0;
            r_s1_triple  <= '0;
        end else begin
            r_s1_valid   <= w_chk;
            r_s1_base_ok <= w_base_ok;
            r_s1_rule5   <= w_rule5;
            r_s1_e       <= w_e;
            r_s1_prod    <= w_prod[47:23];
            r_s1_triple  <= {w_a, w_b, result};
        end
    end

    // r_s1_prod[24] is product bit 47: the 1.x * 1.y product reached [2,4)
    assign w_expn    = r_s1_prod[24] ? (r_s1_e + 10'sd1) : r_s1_e;
    assign w_frac    = r_s1_prod[24] ? r_s1_prod[23:1] : r_s1_prod[22:0];
    assign w_expect  = {w_expn[7:0], w_frac};
    assign w_got     = r_s1_triple[30:0];
    assign w_mant_ok = (w_got == w_expect) || (w_got == w_expect + 31'd1);

    assign w_unused_mant = ^{w_prod[22:0], w_expn[9:8]};

    assign w_upd_valid  = r_s1_valid;
    assign w_upd_fail   = !(r_s1_base_ok && (!r_s1_rule5 || w_mant_ok));
    assign w_upd_triple = r_s1_triple;
`else
    logic w_unused_rule5;

    assign w_unused_rule5 = w_rule5;
    assign w_upd_valid    = w_chk;
    assign w_upd_fail     = !w_base_ok;
    assign w_upd_triple   = {w_a, w_b, result};
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic w_halt_trip;

    assign w_halt_trip = (HALT_ON_ERR != 0) && w_upd_valid && w_upd_fail &&
                         (r_state != S_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_FILL;
                    w_fill_nxt  = '0;
                end
            end
            S_FILL: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_fill == c_fill_last) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_fill_nxt = r_fill + 3'd1;
                end
            end
            S_CHECK: begin
                if (!en) w_state_nxt = S_IDLE;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_halt_trip) w_state_nxt = S_HALT;
    end

    // ------------------------------------------------------------------
    // Statistics and first-error capture; everything freezes in HALT
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pass_count <= '0;
            r_err_count  <= '0;
            r_err_flag   <= 1'b0;
            r_first_err  <= '0;
        end else if (w_upd_valid && (r_state != S_HALT)) begin
            if (!w_upd_fail) begin
                if (r_pass_count != '1) r_pass_count <= r_pass_count + 32'd1;
            end else begin
                if (r_err_count != '1) r_err_count <= r_err_count + 16'd1;
                if (!r_err_flag) begin
                    r_err_flag  <= 1'b1;
                    r_first_err <= w_upd_triple;
                end
            end
        end
    end

    assign pass_count = r_pass_count;
    assign err_count  = r_err_count;
    assign err_flag   = r_err_flag;
    assign first_err  = r_first_err;
    assign state      = r_state;

endmodule
`default_nettype wire
